// File: rtl/obstacle_collision_judge.sv
// Obstacle collision judge: shrunk-hitbox overlap test between the dino and
// up to three obstacles, plus the IDLE/RUN/HIT/OVER game state machine with
// frame-divided score and best-score tracking.
module obstacle_collision_judge #(
    parameter int MARGIN     = 2,
    parameter int HIT_FRAMES = 30,
    parameter int SCORE_DIV  = 6
) (
    input  logic               FrameClk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [31:0] dinoX,
    input  logic signed [31:0] dinoY,
    input  logic        [11:0] dinoW,
    input  logic        [11:0] dinoH,
    input  logic signed [31:0] obsX1,
    input  logic signed [31:0] obsX2,
    input  logic signed [31:0] obsX3,
    input  logic signed [31:0] obsY,
    input  logic        [11:0] Obs1_W,
    input  logic        [11:0] Obs1_H,
    input  logic        [11:0] Obs2_W,
    input  logic        [11:0] Obs2_H,
    input  logic        [11:0] Obs3_W,
    input  logic        [11:0] Obs3_H,
    output logic        [1:0]  gameState,
    output logic               hit,
    output logic        [1:0]  hitIndex,
    output logic        [15:0] score,
    output logic        [15:0] highScore
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HIT  = 2'b10,
        S_OVER = 2'b11
    } state_t;

    localparam int DIV_W  = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam int HCNT_W = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCORE_DIV - 1);
    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HIT_FRAMES - 1);
    localparam logic signed [32:0] MARGIN_S = 33'(MARGIN);
    localparam logic [11:0] MIN_SIZE = 12'(2 * MARGIN);

    // Sign-extend a coordinate to 33 bits so x+w never wraps.
    function automatic logic signed [32:0] sext33(input logic signed [31:0] v);
        return {v[31], v};
    endfunction

    // Zero-extend an unsigned size to 33 bits.
    function automatic logic signed [32:0] zext33(input logic [11:0] v);
        return {21'd0, v};
    endfunction

    // Shrunk dino box, half-open on the right/bottom edges.
    logic signed [32:0] dino_l, dino_r, dino_t, dino_b;
    logic               dino_ok;

    assign dino_l  = sext33(dinoX) + MARGIN_S;
    assign dino_r  = sext33(dinoX) + zext33(dinoW) - MARGIN_S;
    assign dino_t  = sext33(dinoY) + MARGIN_S;
    assign dino_b  = sext33(dinoY) + zext33(dinoH) - MARGIN_S;
    assign dino_ok = (dinoW > MIN_SIZE) && (dinoH > MIN_SIZE);

    logic signed [31:0] obs_x [3];
    logic        [11:0] obs_w [3];
    logic        [11:0] obs_h [3];
    logic        [2:0]  coll;

    assign obs_x[0] = obsX1;
    assign obs_x[1] = obsX2;
    assign obs_x[2] = obsX3;
    assign obs_w[0] = Obs1_W;
    assign obs_w[1] = Obs2_W;
    assign obs_w[2] = Obs3_W;
    assign obs_h[0] = Obs1_H;
    assign obs_h[1] = Obs2_H;
    assign obs_h[2] = Obs3_H;

    // Per-obstacle strict overlap against the dino; edge contact does not count.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_obs
            logic signed [32:0] o_l, o_r, o_t, o_b;
            logic               o_ok;

            assign o_l  = sext33(obs_x[gi]) + MARGIN_S;
            assign o_r  = sext33(obs_x[gi]) + zext33(obs_w[gi]) - MARGIN_S;
            assign o_t  = sext33(obsY) + MARGIN_S;
            assign o_b  = sext33(obsY) + zext33(obs_h[gi]) - MARGIN_S;
            assign o_ok = (obs_w[gi] != 12'd0) && (obs_w[gi] > MIN_SIZE) &&
                          (obs_h[gi] > MIN_SIZE);

            assign coll[gi] = o_ok && dino_ok &&
                              (dino_l < o_r) && (o_l < dino_r) &&
                              (dino_t < o_b) && (o_t < dino_b);
        end
    endgenerate

    logic       any_coll;
    logic [1:0] first_idx;

    assign any_coll = |coll;

    // Lowest-numbered colliding obstacle wins.
    always_comb begin
        first_idx = 2'd0;
        if (coll[0])      first_idx = 2'd1;
        else if (coll[1]) first_idx = 2'd2;
        else if (coll[2]) first_idx = 2'd3;
    end

    state_t              state_q, state_d;
    logic                hit_q, hit_d;
    logic [1:0]          idx_q, idx_d;
    logic [15:0]         score_q, score_d;
    logic [15:0]         high_q, high_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d;

    // Game state, score divider, hit timer and best-score next-state logic.
    always_comb begin
        state_d = state_q;
        hit_d   = 1'b0;
        idx_d   = idx_q;
        score_d = score_q;
        high_d  = high_q;
        div_d   = div_q;
        hcnt_d  = hcnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    score_d = 16'd0;
                    div_d   = '0;
                end
            end
            S_RUN: begin
                if (any_coll) begin
                    state_d = S_HIT;
                    hit_d   = 1'b1;
                    idx_d   = first_idx;
                    hcnt_d  = '0;
                end else if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_HIT: begin
                if (hcnt_q == HCNT_LAST) begin
                    state_d = S_OVER;
                    hcnt_d  = '0;
                    if (score_q > high_q) high_d = score_q;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            S_OVER: begin
                if (start) begin
                    state_d = S_RUN;
                    score_d = 16'd0;
                    div_d   = '0;
                    idx_d   = 2'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous reset back to an idle, zeroed game.
    always_ff @(posedge FrameClk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            hit_q   <= 1'b0;
            idx_q   <= 2'd0;
            score_q <= 16'd0;
            high_q  <= 16'd0;
            div_q   <= '0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
            score_q <= score_d;
            high_q  <= high_d;
            div_q   <= div_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign gameState = state_q;
    assign hit       = hit_q;
    assign hitIndex  = idx_q;
    assign score     = score_q;
    assign highScore = high_q;

endmodule

// File: tb/tb_obstacle_collision_judge.sv
// Testbench for obstacle_collision_judge: directed scenarios with literal
// expectations plus randomized play checked every frame against a model.
module tb_obstacle_collision_judge;

    localparam int MARGIN     = 2;
    localparam int HIT_FRAMES = 30;
    localparam int SCORE_DIV  = 6;

    logic               FrameClk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic signed [31:0] dinoX, dinoY, obsX1, obsX2, obsX3, obsY;
    logic        [11:0] dinoW, dinoH;
    logic        [11:0] Obs1_W, Obs1_H, Obs2_W, Obs2_H, Obs3_W, Obs3_H;
    logic        [1:0]  gameState;
    logic               hit;
    logic        [1:0]  hitIndex;
    logic        [15:0] score;
    logic        [15:0] highScore;

    int total = 0;
    int bad   = 0;

    obstacle_collision_judge #(
        .MARGIN(MARGIN), .HIT_FRAMES(HIT_FRAMES), .SCORE_DIV(SCORE_DIV)
    ) dut (
        .FrameClk(FrameClk), .rst(rst), .start(start),
        .dinoX(dinoX), .dinoY(dinoY), .dinoW(dinoW), .dinoH(dinoH),
        .obsX1(obsX1), .obsX2(obsX2), .obsX3(obsX3), .obsY(obsY),
        .Obs1_W(Obs1_W), .Obs1_H(Obs1_H), .Obs2_W(Obs2_W), .Obs2_H(Obs2_H),
        .Obs3_W(Obs3_W), .Obs3_H(Obs3_H),
        .gameState(gameState), .hit(hit), .hitIndex(hitIndex),
        .score(score), .highScore(highScore)
    );

    always #5 FrameClk = ~FrameClk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_state  = 0;   // 0 IDLE 1 RUN 2 HIT 3 OVER
    int m_hit    = 0;
    int m_idx    = 0;
    int m_run    = 0;   // collision-free RUN frames since the game began
    int m_high   = 0;
    int m_hedges = 0;   // edges spent in HIT so far

    function automatic int mscore();
        int s;
        s = m_run / SCORE_DIV;
        return (s > 65535) ? 65535 : s;
    endfunction

    // Lowest index whose shrunk box strictly overlaps the shrunk dino box.
    function automatic int first_hit();
        longint ox [3];
        int     ow [3];
        int     oh [3];
        longint dl, dr, dt, db, ol, orr, ot, ob;
        ox[0] = longint'(obsX1); ox[1] = longint'(obsX2); ox[2] = longint'(obsX3);
        ow[0] = int'(Obs1_W); ow[1] = int'(Obs2_W); ow[2] = int'(Obs3_W);
        oh[0] = int'(Obs1_H); oh[1] = int'(Obs2_H); oh[2] = int'(Obs3_H);
        if (int'(dinoW) <= 2 * MARGIN || int'(dinoH) <= 2 * MARGIN) return 0;
        dl = longint'(dinoX) + MARGIN;
        dr = longint'(dinoX) + longint'(dinoW) - MARGIN;
        dt = longint'(dinoY) + MARGIN;
        db = longint'(dinoY) + longint'(dinoH) - MARGIN;
        for (int k = 0; k < 3; k++) begin
            if (ow[k] == 0 || ow[k] <= 2 * MARGIN || oh[k] <= 2 * MARGIN) continue;
            ol  = ox[k] + MARGIN;
            orr = ox[k] + ow[k] - MARGIN;
            ot  = longint'(obsY) + MARGIN;
            ob  = longint'(obsY) + oh[k] - MARGIN;
            if (dl < orr && ol < dr && dt < ob && ot < db) return k + 1;
        end
        return 0;
    endfunction

    always @(posedge FrameClk or posedge rst) begin
        if (rst) begin
            m_state <= 0; m_hit <= 0; m_idx <= 0;
            m_run <= 0; m_high <= 0; m_hedges <= 0;
        end else begin
            m_hit <= 0;
            case (m_state)
                0: if (start) begin m_state <= 1; m_run <= 0; end
                1: begin
                    if (first_hit() != 0) begin
                        m_state <= 2; m_hit <= 1; m_idx <= first_hit(); m_hedges <= 0;
                    end else begin
                        m_run <= m_run + 1;
                    end
                end
                2: begin
                    m_hedges <= m_hedges + 1;
                    if (m_hedges + 1 == HIT_FRAMES) begin
                        m_state <= 3;
                        if (mscore() > m_high) m_high <= mscore();
                    end
                end
                default: if (start) begin m_state <= 1; m_run <= 0; m_idx <= 0; end
            endcase
        end
    end

    // Every-frame comparison of the DUT against the model.
    always @(negedge FrameClk) begin
        chk("cyc_state", 32'(gameState), 32'(m_state));
        chk("cyc_hit",   32'(hit),       32'(m_hit));
        chk("cyc_idx",   32'(hitIndex),  32'(m_idx));
        chk("cyc_score", 32'(score),     32'(mscore()));
        chk("cyc_high",  32'(highScore), 32'(m_high));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge FrameClk);
        #1;
    endtask

    task automatic set_default();
        dinoX = 50; dinoY = 100; dinoW = 12'd20; dinoH = 12'd20;
        obsX1 = 300; obsX2 = 300; obsX3 = 300; obsY = 105;
        Obs1_W = 12'd0; Obs2_W = 12'd0; Obs3_W = 12'd0;
        Obs1_H = 12'd20; Obs2_H = 12'd20; Obs3_H = 12'd20;
    endtask

    // One full game from IDLE/OVER: n points, a collision, then the HIT timeout.
    task automatic play_game(input int n, input int exp_high);
        start = 1'b1; step(); start = 1'b0;
        chk("game_run", 32'(gameState), 32'd1);
        repeat (n * SCORE_DIV) step();
        chk("game_score", 32'(score), 32'(n));
        obsX1 = 60; Obs1_W = 12'd10; step(); Obs1_W = 12'd0;
        chk("game_hitstate", 32'(gameState), 32'd2);
        repeat (HIT_FRAMES) step();
        chk("game_over", 32'(gameState), 32'd3);
        chk("game_high", 32'(highScore), 32'(exp_high));
    endtask

    task automatic rand_inputs();
        dinoX = 32'(40 + $urandom_range(0, 20));
        dinoY = 100;
        dinoW = 12'($urandom_range(3, 25));
        dinoH = 12'($urandom_range(3, 25));
        obsY  = 32'(90 + $urandom_range(0, 30));
        obsX1 = 32'(20 + $urandom_range(0, 80));
        obsX2 = 32'(20 + $urandom_range(0, 80));
        obsX3 = 32'(20 + $urandom_range(0, 80));
        Obs1_W = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(1, 20)) : 12'd0;
        Obs2_W = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(1, 20)) : 12'd0;
        Obs3_W = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(1, 20)) : 12'd0;
        Obs1_H = 12'($urandom_range(1, 25));
        Obs2_H = 12'($urandom_range(1, 25));
        Obs3_H = 12'($urandom_range(1, 25));
        if ($urandom_range(0, 19) == 0) begin
            // Near the top of the signed range: x+w only fits in 33 bits.
            dinoX = 32'sh7FFF_FFF0;
            obsX1 = 32'sh7FFF_FFF8;
            obsX2 = 32'sh8000_0000;
            Obs2_W = 12'hFFF;
        end
        start = ($urandom_range(0, 3) == 0);
    endtask

    // ---------------- directed + random scenarios ----------------
    initial begin
        set_default();
        repeat (3) step();
        chk("rst_state", 32'(gameState), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        rst = 1'b0;
        step();

        // start for one frame, then 60 obstacle-free frames
        start = 1'b1; step(); start = 1'b0;
        chk("start_run", 32'(gameState), 32'd1);
        repeat (60) step();
        chk("score60", 32'(score), 32'd10);
        chk("mdl_score60", 32'(mscore()), 32'd10);

        // obstacle 2 overlapping
        obsX2 = 60; Obs2_W = 12'd10; step(); Obs2_W = 12'd0;
        chk("hit_pulse", 32'(hit), 32'd1);
        chk("hit_idx2", 32'(hitIndex), 32'd2);
        chk("hit_state", 32'(gameState), 32'd2);
        chk("mdl_idx2", 32'(m_idx), 32'd2);
        step();
        chk("hit_one_frame", 32'(hit), 32'd0);
        repeat (HIT_FRAMES - 2) step();
        chk("still_hit", 32'(gameState), 32'd2);
        step();
        chk("over", 32'(gameState), 32'd3);
        chk("high10", 32'(highScore), 32'd10);
        chk("idx_held", 32'(hitIndex), 32'd2);

        // edge-touching vs. one-pixel overlap
        start = 1'b1; step(); start = 1'b0;
        chk("restart_score", 32'(score), 32'd0);
        chk("restart_idx", 32'(hitIndex), 32'd0);
        obsX1 = 66; Obs1_W = 12'd20;
        repeat (4) step();
        chk("touch_nohit", 32'(gameState), 32'd1);
        chk("mdl_touch", 32'(m_state), 32'd1);
        obsX1 = 65; step(); Obs1_W = 12'd0;
        chk("overlap_hit", 32'(hit), 32'd1);
        chk("overlap_idx1", 32'(hitIndex), 32'd1);
        repeat (HIT_FRAMES) step();

        // obstacles 1 and 3 together while start held
        start = 1'b1; step();
        obsX1 = 55; Obs1_W = 12'd10; obsX3 = 60; Obs3_W = 12'd10;
        step(); start = 1'b0; Obs1_W = 12'd0; Obs3_W = 12'd0;
        chk("multi_idx1", 32'(hitIndex), 32'd1);
        chk("multi_state", 32'(gameState), 32'd2);
        repeat (HIT_FRAMES) step();

        // high score across three games
        rst = 1'b1; step(); rst = 1'b0;
        play_game(25, 25);
        play_game(12, 25);
        play_game(40, 40);
        start = 1'b1; step(); start = 1'b0;
        chk("g3_restart_score", 32'(score), 32'd0);
        chk("g3_keep_high", 32'(highScore), 32'd40);

        // randomized play
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1; step(); rst = 1'b0;
            end else begin
                step();
            end
        end
        set_default(); start = 1'b0;

        // reset in the middle of HIT
        rst = 1'b1; step(); rst = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        repeat (12) step();
        obsX1 = 60; Obs1_W = 12'd10; step(); Obs1_W = 12'd0;
        chk("pre_rst_hit", 32'(gameState), 32'd2);
        repeat (10) step();
        #1 rst = 1'b1;
        #1;
        chk("arst_state", 32'(gameState), 32'd0);
        chk("arst_hit", 32'(hit), 32'd0);
        chk("arst_idx", 32'(hitIndex), 32'd0);
        chk("arst_score", 32'(score), 32'd0);
        chk("arst_high", 32'(highScore), 32'd0);
        step(); rst = 1'b0;
        obsX1 = 60; Obs1_W = 12'd10;
        repeat (5) step();
        chk("idle_ignore_state", 32'(gameState), 32'd0);
        chk("idle_ignore_hit", 32'(hit), 32'd0);
        chk("idle_ignore_idx", 32'(hitIndex), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
